i2c_slave_sync: RTL and testbench

Fully synchronous I2C slave with an attached register-map port. All logic runs on one system clock, with SCL/SDA oversampled, synchronised and glitch-filtered. It supersedes the SCL-clocked slave and adds a parametrised register-address length, input filtering, open-drain output-enable drive, a read-request strobe and a repeated-START path. It sits between the board-level I2C pads and a byte-wide register file.

---
 rtl/i2c_slave_sync.sv | 219 +++++++++++++++++++++
 tb/tb_i2c_slave_sync.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_sync.sv
// Fully synchronous I2C slave with a byte-wide register-file port.
// SCL/SDA are synchronised, glitch-filtered and edge-detected on clk.
module i2c_slave_sync #(
    parameter int ADDR_BYTES = 1,
    parameter int FILTER_LEN = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              slave_id,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    sda_oe,
    output logic                    i2c_active,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic [8*ADDR_BYTES-1:0] addr,
    output logic [7:0]              wdata,
    output logic                    wr_pulse,
    output logic                    rd_pulse,
    input  logic [7:0]              rdata
);

    // state      | meaning
    // S_IDLE     | wait for START
    // S_ADDR     | shift in device address byte
    // S_ADDR_ACK | drive ACK for a matching device address
    // S_REG_ADDR | receive register-address byte(s)
    // S_WRITE    | receive data bytes, strobe wr_pulse
    // S_READ     | shift rdata out on SDA
    // S_READ_ACK | sample master ACK/NACK
    localparam int AW = 8 * ADDR_BYTES;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_REG_ADDR = 3'd3;
    localparam logic [2:0] S_WRITE    = 3'd4;
    localparam logic [2:0] S_READ     = 3'd5;
    localparam logic [2:0] S_READ_ACK = 3'd6;

    localparam logic [3:0] FLT_MAX  = 4'(FILTER_LEN - 1);
    localparam logic [1:0] LAST_REG = 2'(ADDR_BYTES - 1);

    // index 0 = SCL, index 1 = SDA
    logic [1:0]      sync1, sync2, filt, filt_d;
    logic [1:0][3:0] flt_cnt;

    logic [2:0]    state;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_cnt;
    logic [7:0]    shift;
    logic [AW-1:0] addr_acc;
    logic          rd_load;

    logic          scl_rise, scl_fall, sda_rise, sda_fall;
    logic          start_det, stop_det;
    logic [AW+7:0] acc_cat;
    logic [AW-1:0] addr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            flt_cnt <= '0;
        end else begin
            sync1  <= {sda_in, scl_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_MAX) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_rise  =  filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] &  filt_d[0];
    assign sda_rise  =  filt[1] & ~filt_d[1];
    assign sda_fall  = ~filt[1] &  filt_d[1];
    // SCL must be high on both sides of the SDA edge to qualify as START/STOP
    assign start_det = sda_fall & filt[0] & filt_d[0];
    assign stop_det  = sda_rise & filt[0] & filt_d[0];

    assign acc_cat  = {addr_acc, shift};
    assign addr_nxt = acc_cat[AW-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            addr_acc   <= '0;
            rd_load    <= 1'b0;
            sda_oe     <= 1'b0;
            i2c_active <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            wr_pulse   <= 1'b0;
            rd_pulse   <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            rd_pulse <= 1'b0;
            rd_load  <= rd_pulse;
            if (wr_pulse) addr <= addr + AW'(1);
            // rdata is captured two clocks after the request strobe
            if (rd_load) shift <= rdata;

            if (start_det) begin
                state      <= S_ADDR;
                bit_cnt    <= '0;
                i2c_active <= 1'b1;
                wr_en      <= 1'b0;
                rd_en      <= 1'b0;
                sda_oe     <= 1'b0;
            end else if (stop_det) begin
                state      <= S_IDLE;
                i2c_active <= 1'b0;
                wr_en      <= 1'b0;
                rd_en      <= 1'b0;
                sda_oe     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shift   <= {shift[6:0], filt[1]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift[7:1] == slave_id) begin
                                sda_oe <= 1'b1;
                                state  <= S_ADDR_ACK;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (shift[0]) begin
                                rd_en    <= 1'b1;
                                rd_pulse <= 1'b1;
                                state    <= S_READ;
                            end else begin
                                wr_en    <= 1'b1;
                                byte_cnt <= '0;
                                state    <= S_REG_ADDR;
                            end
                        end
                    end
                    S_REG_ADDR, S_WRITE: begin
                        // first fall of a byte ends our ACK, the 8th fall starts the next one
                        if (scl_fall && bit_cnt == 4'd0) sda_oe <= 1'b0;
                        else if (scl_fall && bit_cnt == 4'd8) sda_oe <= 1'b1;
                        if (scl_rise) begin
                            if (bit_cnt != 4'd8) begin
                                shift   <= {shift[6:0], filt[1]};
                                bit_cnt <= bit_cnt + 4'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (state == S_WRITE) begin
                                    wdata    <= shift;
                                    wr_pulse <= 1'b1;
                                end else begin
                                    addr_acc <= addr_nxt;
                                    if (byte_cnt == LAST_REG) begin
                                        addr  <= addr_nxt;
                                        state <= S_WRITE;
                                    end else begin
                                        byte_cnt <= byte_cnt + 2'd1;
                                    end
                                end
                            end
                        end
                    end
                    S_READ: begin
                        if (scl_rise && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe <= ~shift[7];
                            end else if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= S_READ_ACK;
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    S_READ_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= '0;
                            if (!filt[1]) begin
                                addr     <= addr + AW'(1);
                                rd_pulse <= 1'b1;
                                state    <= S_READ;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_sync.sv
// Bench for i2c_slave_sync: a bit-banged master drives a shared bus with a
// 1-byte-address slave (id 0x24) and a 2-byte-address slave (id 0x30).
module tb_i2c_slave_sync;
    localparam int Q = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       scl_m, sda_m;
    logic [6:0] id1 = 7'h24;
    logic [6:0] id2 = 7'h30;

    logic        oe1, act1, wen1, ren1, wp1, rp1;
    logic [7:0]  addr1, wdata1, rdata1;
    logic        oe2, act2, wen2, ren2, wp2, rp2;
    logic [15:0] addr2;
    logic [7:0]  wdata2;
    logic [7:0]  rdata2 = 8'h00;

    logic sda_bus;
    assign sda_bus = sda_m & ~oe1 & ~oe2;

    logic [7:0] rf [256];
    assign rdata1 = rf[addr1];

    i2c_slave_sync #(.ADDR_BYTES(1), .FILTER_LEN(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .slave_id(id1), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(oe1), .i2c_active(act1), .wr_en(wen1), .rd_en(ren1), .addr(addr1),
        .wdata(wdata1), .wr_pulse(wp1), .rd_pulse(rp1), .rdata(rdata1));

    i2c_slave_sync #(.ADDR_BYTES(2), .FILTER_LEN(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .slave_id(id2), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(oe2), .i2c_active(act2), .wr_en(wen2), .rd_en(ren2), .addr(addr2),
        .wdata(wdata2), .wr_pulse(wp2), .rd_pulse(rp2), .rdata(rdata2));

    int n_cmp = 0;
    int n_err = 0;
    int oe1_cnt = 0;

    logic [15:0] exp_wr1 [$];
    logic [23:0] exp_wr2 [$];
    logic [7:0]  exp_rd1 [$];
    logic [15:0] e1;
    logic [23:0] e2;
    logic [7:0]  e3;

    // scoreboard: every strobe pops and checks the next expected transfer
    always @(negedge clk) begin
        if (oe1) oe1_cnt++;
        if (wp1) begin
            n_cmp++;
            if (exp_wr1.size() == 0) begin
                n_err++;
                $display("FAIL wr1_unexpected: got addr=%h wdata=%h, required no strobe", addr1, wdata1);
            end else begin
                e1 = exp_wr1.pop_front();
                if ({addr1, wdata1} !== e1) begin
                    n_err++;
                    $display("FAIL wr1_data: got %h/%h, required %h/%h", addr1, wdata1, e1[15:8], e1[7:0]);
                end
            end
        end
        if (wp2) begin
            n_cmp++;
            if (exp_wr2.size() == 0) begin
                n_err++;
                $display("FAIL wr2_unexpected: got addr=%h wdata=%h, required no strobe", addr2, wdata2);
            end else begin
                e2 = exp_wr2.pop_front();
                if ({addr2, wdata2} !== e2) begin
                    n_err++;
                    $display("FAIL wr2_data: got %h/%h, required %h/%h", addr2, wdata2, e2[23:8], e2[7:0]);
                end
            end
        end
        if (rp1) begin
            n_cmp++;
            if (exp_rd1.size() == 0) begin
                n_err++;
                $display("FAIL rd1_unexpected: got addr=%h, required no strobe", addr1);
            end else begin
                e3 = exp_rd1.pop_front();
                if (addr1 !== e3) begin
                    n_err++;
                    $display("FAIL rd1_addr: got %h, required %h", addr1, e3);
                end
            end
        end
    end

    task automatic wait_q(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input logic glitch, output logic s);
        wait_q(Q);
        sda_m = b;
        wait_q(Q);
        scl_m = 1'b1;
        if (glitch) begin
            wait_q(6);
            scl_m = 1'b0;
            wait_q(2);
            scl_m = 1'b1;
            wait_q(Q - 8);
        end else begin
            wait_q(Q);
        end
        s = sda_bus;
        wait_q(Q);
        scl_m = 1'b0;
    endtask

    task automatic do_start;
        sda_m = 1'b1;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q);
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b0;
    endtask

    task automatic do_stop;
        sda_m = 1'b0;
        wait_q(Q);
        scl_m = 1'b1;
        wait_q(Q);
        sda_m = 1'b1;
        wait_q(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch && (i == 3), s);
        clk_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        clk_bit(~mack, 1'b0, s);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_q(5);
        n_cmp++;
        if ({oe1, act1, wen1, ren1, wp1, rp1} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags1: got %b, required 000000", {oe1, act1, wen1, ren1, wp1, rp1});
        end
        n_cmp++;
        if ({addr1, wdata1} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_regs1: got %h, required 0000", {addr1, wdata1});
        end
        n_cmp++;
        if ({oe2, act2, wen2, ren2, wp2, rp2, addr2} !== 22'h0) begin
            n_err++;
            $display("FAIL reset_dut2: got %h, required 0", {oe2, act2, wen2, ren2, wp2, rp2, addr2});
        end
        rst_n = 1'b1;
        wait_q(10);
    endtask

    task automatic test_write;
        logic [3:0] a;
        do_start;
        send_byte(8'h48, 1'b0, a[3]);
        n_cmp++;
        if (act1 !== 1'b1) begin
            n_err++;
            $display("FAIL write_active: got %b, required 1", act1);
        end
        send_byte(8'h10, 1'b0, a[2]);
        exp_wr1.push_back({8'h10, 8'hA5});
        send_byte(8'hA5, 1'b0, a[1]);
        exp_wr1.push_back({8'h11, 8'h5A});
        send_byte(8'h5A, 1'b0, a[0]);
        n_cmp++;
        if ({a, wen1, ren1} !== 6'b111110) begin
            n_err++;
            $display("FAIL write_acks_en: got %b, required 111110", {a, wen1, ren1});
        end
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({wen1, act1, exp_wr1.size() == 0} !== 3'b001) begin
            n_err++;
            $display("FAIL write_stop: got wen/act/drained=%b, required 001", {wen1, act1, exp_wr1.size() == 0});
        end
    endtask

    task automatic test_read_rs;
        logic [2:0] a;
        logic [7:0] b0, b1;
        do_start;
        send_byte(8'h48, 1'b0, a[2]);
        send_byte(8'h20, 1'b0, a[1]);
        do_start;
        exp_rd1.push_back(8'h20);
        send_byte(8'h49, 1'b0, a[0]);
        n_cmp++;
        if ({a, ren1, wen1} !== 5'b11110) begin
            n_err++;
            $display("FAIL read_acks_en: got %b, required 11110", {a, ren1, wen1});
        end
        exp_rd1.push_back(8'h21);
        recv_byte(1'b1, b0);
        recv_byte(1'b0, b1);
        n_cmp++;
        if ({b0, b1} !== 16'h3CC3) begin
            n_err++;
            $display("FAIL read_data: got %h, required 3cc3", {b0, b1});
        end
        wait_q(Q);
        n_cmp++;
        if ({oe1, ren1} !== 2'b01) begin
            n_err++;
            $display("FAIL read_nack_release: got oe/ren=%b, required 01", {oe1, ren1});
        end
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({ren1, act1, exp_rd1.size() == 0} !== 3'b001) begin
            n_err++;
            $display("FAIL read_stop: got ren/act/drained=%b, required 001", {ren1, act1, exp_rd1.size() == 0});
        end
    endtask

    task automatic test_mismatch;
        logic a;
        int base;
        base = oe1_cnt;
        do_start;
        send_byte(8'h4A, 1'b0, a);
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({a, wen1, ren1, oe1_cnt != base} !== 4'b0000) begin
            n_err++;
            $display("FAIL mismatch: got ack/wen/ren/oe_seen=%b, required 0000", {a, wen1, ren1, oe1_cnt != base});
        end
    endtask

    task automatic test_wrap;
        logic [4:0] a;
        do_start;
        send_byte(8'h60, 1'b0, a[4]);
        send_byte(8'hFF, 1'b0, a[3]);
        send_byte(8'hFF, 1'b0, a[2]);
        exp_wr2.push_back({16'hFFFF, 8'h11});
        send_byte(8'h11, 1'b0, a[1]);
        exp_wr2.push_back({16'h0000, 8'h22});
        send_byte(8'h22, 1'b0, a[0]);
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({a, addr2} !== {5'b11111, 16'h0001}) begin
            n_err++;
            $display("FAIL wrap: got acks=%b addr=%h, required 11111/0001", a, addr2);
        end
        n_cmp++;
        if (exp_wr2.size() != 0) begin
            n_err++;
            $display("FAIL wrap_drained: got %0d pending, required 0", exp_wr2.size());
        end
    endtask

    task automatic test_glitch;
        logic [2:0] a;
        do_start;
        send_byte(8'h48, 1'b0, a[2]);
        send_byte(8'h50, 1'b0, a[1]);
        exp_wr1.push_back({8'h50, 8'h96});
        send_byte(8'h96, 1'b1, a[0]);
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({a, exp_wr1.size() == 0} !== 4'b1111) begin
            n_err++;
            $display("FAIL glitch: got acks/drained=%b, required 1111", {a, exp_wr1.size() == 0});
        end
    endtask

    task automatic test_abort;
        logic [2:0] a;
        logic       s;
        // STOP in the middle of a data byte
        do_start;
        send_byte(8'h48, 1'b0, a[2]);
        send_byte(8'h30, 1'b0, a[1]);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, s);
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({a[2:1], wen1, act1, oe1} !== 5'b11000) begin
            n_err++;
            $display("FAIL abort_stop: got %b, required 11000", {a[2:1], wen1, act1, oe1});
        end
        // reset while the slave is driving a read bit low
        do_start;
        send_byte(8'h48, 1'b0, a[2]);
        send_byte(8'h20, 1'b0, a[1]);
        do_start;
        exp_rd1.push_back(8'h20);
        send_byte(8'h49, 1'b0, a[0]);
        clk_bit(1'b1, 1'b0, s);
        wait_q(Q);
        n_cmp++;
        if ({a, oe1} !== 4'b1111) begin
            n_err++;
            $display("FAIL abort_pre_reset: got acks/oe=%b, required 1111", {a, oe1});
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (oe1 !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset_release: got oe=%b, required 0", oe1);
        end
        wait_q(3);
        rst_n = 1'b1;
        wait_q(10);
        do_stop;
        // next transaction must work normally
        do_start;
        send_byte(8'h48, 1'b0, a[2]);
        send_byte(8'h40, 1'b0, a[1]);
        exp_wr1.push_back({8'h40, 8'h77});
        send_byte(8'h77, 1'b0, a[0]);
        do_stop;
        wait_q(10);
        n_cmp++;
        if ({a, exp_wr1.size() == 0, exp_rd1.size() == 0} !== 5'b11111) begin
            n_err++;
            $display("FAIL abort_recover: got acks/drained=%b, required 11111",
                     {a, exp_wr1.size() == 0, exp_rd1.size() == 0});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rf[i] = 8'(i);
        rf[8'h20] = 8'h3C;
        rf[8'h21] = 8'hC3;
        test_reset;
        test_write;
        test_read_rs;
        test_mismatch;
        test_wrap;
        test_glitch;
        test_abort;
        wait_q(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
